stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream stream consumer (e.g. an ap01/ap02
//  primitive instance) between N upstream stream producers. Each input is an
//  intN word with valid/ready. The output is a registered word, its source tag,
//  and valid/ready. A grant is held for a bounded burst so that one stream cannot
//  starve the others. It sits between producer primitives and the `sync port of
//  the shared consumer.
// PARAMETERS
//  N      4       number of requester streams (1..16)
//  W      `intN   data word width
//  BURST  4       max words accepted per grant (1..255)
//  TAGW   $clog2(N) (min 1)  width of out_tag
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      asynchronous active-high reset
//  in_data    in   N*W    word i at [i*W +: W]
//  in_valid   in   N      requester i offers in_data[i]
//  in_ready   out  N      word i accepted this cycle when valid&ready
//  out_data   out  W      registered word to shared consumer
//  out_tag    out  TAGW   index of the requester that produced out_data
//  out_valid  out  1      out_data/out_tag valid
//  out_ready  in   1      consumer accepts out word
//  busy       out  1      state==HOLD or out_valid
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant=0, cnt=0, out_valid=0, out_data=0, out_tag=0.
//   in_ready=0 and busy=0 while rst is high. Async assert; deassert is taken at the next posedge.
//  FSM IDLE:
//   - If any in_valid is set, pick the first set bit at or after rr_ptr (wrapping).
//   - Latch grant=g and cnt=0, then go to HOLD. in_ready is all 0 in IDLE.
//   - This costs one arbitration cycle per grant.
//  FSM HOLD:
//   - in_ready[grant] = !out_valid | out_ready. All other in_ready bits are 0.
//   - On transfer (in_valid[g]&in_ready[g]): out_data<=word, out_tag<=g, out_valid<=1, cnt<=cnt+1.
//   - If cnt+1==BURST on a transfer: go to IDLE and set rr_ptr<=(g+1)%N.
//   - If in_valid[g]==0 in HOLD (requester drained): go to IDLE and set rr_ptr<=(g+1)%N.
//     No transfer happens that cycle.
//  Output register:
//   - out_valid clears when out_ready=1 and no new transfer occurs that cycle.
//   - While out_valid&!out_ready, out_data and out_tag hold stable.
//   - Load and drain in the same cycle sustain 1 word/clk.
//  Latency: input transfer at edge k -> out_valid at k (visible after edge k), i.e. 1 register stage.
//  Boundaries:
//   - N=1: rr_ptr is always 0.
//   - BURST=1: every word re-arbitrates.
//   - Wrap: g=N-1 sets rr_ptr=0.
//   - cnt never exceeds BURST-1 at rest.
//   - All in_valid low: stay IDLE, out_valid drains normally.
//   - Reset mid-burst: the in-flight out word is dropped and rr_ptr returns to 0.
//  Protocol: a producer must hold in_data stable while in_valid&!in_ready.
//   Dropping valid is a release, not an error.
// STRUCTURE
//  Shared package/include (primitives.v):
//   - `intN, `true/`false, stream wire/reg macros.
//   - Add localparams S_IDLE=1'b0 and S_HOLD=1'b1 to a shared arbiter include.
//  Sub-module rr_priority_pick(N): combinational rotating priority encoder.
//   (req[N], ptr[TAGW]) -> (any, idx[TAGW]). Reusable by future schedulers.
//  Top: FSM, burst counter, rr_ptr, output register.
// TESTING (N=4, W=8, BURST=4, out_ready=1 unless stated)
//  1. Reset: all in_valid=1 during rst -> in_ready=0, out_valid=0; after release first grant=0.
//  2. Single stream:
//     - only in_valid[2]=1 with data 10,11,12...
//     - out_tag=2 for 4 words, 1 IDLE bubble, regrant 2.
//     - Pattern 4 words per 5 clks.
//  3. Fairness:
//     - all valid, data i*16+k.
//     - Out tags 0,0,0,0,1,1,1,1,2,...,3, then 0 again.
//     - No source gets >4 consecutive words.
//  4. Backpressure:
//     - hold out_ready=0 for 3 clks mid-burst.
//     - out_data/out_tag stable, in_ready=0, no word lost or duplicated.
//     - Burst count resumes correctly.
//  5. Early release:
//     - req 1 drops valid after 2 words while 3 waits.
//     - Next grant=3 (ptr=2 skips idle 2), out tags 1,1,3,3,...
//  6. Async reset mid-burst:
//     - assert rst between edges with out_valid=1.
//     - out_valid=0 immediately; after release, arbitration restarts at 0.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter.
//   state_e   : arbiter FSM encoding (idle / holding a grant)
//   tag_width : width of a requester index, never less than one bit
//   wrap_inc  : modulo-n increment used to advance the round-robin pointer
package stream_rr_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  localparam int unsigned CntW = 8;  // holds burst lengths up to 255

  function automatic int unsigned tag_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// Combinational rotating priority encoder.
//   req  : request vector, one bit per requester
//   ptr  : index with highest priority; priority falls off with wrap-around
//   any  : at least one request is set
//   idx  : first set request at or after ptr (0 when any is low)
module stream_rr_arbiter_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned TAGW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [TAGW-1:0] ptr,
  output logic            any,
  output logic [TAGW-1:0] idx
);

  int unsigned cand;

  // Scan from the lowest priority upwards so the last hit is the winner.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      cand = (32'(ptr) + unsigned'(off)) % N;
      if (req[cand[TAGW-1:0]]) begin
        any = 1'b1;
        idx = cand[TAGW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one downstream stream consumer between N producers.
// A grant is held for at most BURST words, or until the granted producer drops
// valid, after which the pointer moves past the granted requester.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : N packed words, word i at [i*W +: W]
//   in_valid   : per-requester valid
//   in_ready   : per-requester ready (only the granted bit can be set)
//   out_data   : registered word to the shared consumer
//   out_tag    : index of the requester that produced out_data
//   out_valid  : out_data/out_tag valid
//   out_ready  : consumer accepts the output word
//   busy       : a grant is held or an output word is pending
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned BURST = 4,
  parameter int unsigned TAGW  = tag_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [TAGW-1:0]   grant_q, grant_d;
  logic [TAGW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q;
  logic [W-1:0]      out_data_q;
  logic [TAGW-1:0]   out_tag_q;

  logic              pick_any;
  logic [TAGW-1:0]   pick_idx;
  logic              hold;
  logic              out_free;
  logic              grant_valid;
  logic              load;
  logic              burst_end;
  logic [TAGW-1:0]   next_ptr;
  logic [W-1:0]      grant_word;

  stream_rr_arbiter_pick #(
    .N    (N),
    .TAGW (TAGW)
  ) u_pick (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hold        = (state_q == StHold);
  // The output register can take a word when empty or being drained this cycle.
  assign out_free    = !out_valid_q || out_ready;
  assign grant_valid = in_valid[grant_q];
  assign load        = hold && grant_valid && out_free;
  assign burst_end   = load && ((32'(cnt_q) + 32'd1) == BURST);
  assign next_ptr    = TAGW'(wrap_inc(32'(grant_q), N));

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_q == TAGW'(i)) begin
        grant_word = in_data[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StHold;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      StHold: begin
        // Release on drain (no transfer that cycle) or on the last word of a burst.
        if (!grant_valid || burst_end) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
        end else if (load) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    in_ready = '0;
    if (hold && out_free) begin
      in_ready[grant_q] = 1'b1;
    end
    busy = hold || out_valid_q;
  end

  // Output register: load wins over drain so back-to-back words flow at 1/clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_word;
      out_tag_q   <= grant_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned BURST = 4;
  localparam int unsigned TAGW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  stream_rr_arbiter #(
    .N     (N),
    .W     (W),
    .BURST (BURST),
    .TAGW  (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Producer models: source i offers base[i]+sent[i] while enabled and below its limit.
  bit          en    [N];
  int unsigned sent  [N];
  int unsigned limit [N];
  int unsigned base  [N];

  logic [TAGW+W-1:0] sb[$];       // {tag, data} in acceptance order
  int unsigned       exp_tag[$];  // expected arbitration order
  int unsigned       acc_cnt;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < int'(N); i++) begin
      in_valid[i]        = en[i] && (sent[i] < limit[i]);
      in_data[i*W +: W]  = W'(base[i] + sent[i]);
    end
  endtask

  // One clock: sample handshakes at the negedge, then drive new inputs after the posedge.
  task automatic step();
    logic [TAGW+W-1:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e[W-1:0]));
        check("out_tag", 32'(out_tag), 32'(e[TAGW+W-1:W]));
      end
      if (exp_tag.size() > 0) begin
        check("arb_order", 32'(out_tag), exp_tag.pop_front());
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (in_valid[i] && in_ready[i]) begin
        sb.push_back({TAGW'(i), in_data[i*W +: W]});
        sent[i]++;
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  function automatic bit producers_pending();
    for (int i = 0; i < int'(N); i++) begin
      if (en[i] && sent[i] < limit[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_until_sent(int unsigned budget);
    int unsigned n = 0;
    while (producers_pending() && n < budget) begin
      step();
      n++;
    end
    check("sent_in_budget", 32'(producers_pending()), 32'd0);
  endtask

  task automatic drain();
    int unsigned n = 0;
    for (int i = 0; i < int'(N); i++) en[i] = 1'b0;
    drive_inputs();
    while ((sb.size() > 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    check("drain_sb", 32'(sb.size()), 32'd0);
    check("drain_tags", 32'(exp_tag.size()), 32'd0);
  endtask

  task automatic setup_src(int i, bit e, int unsigned b, int unsigned lim);
    en[i]    = e;
    base[i]  = b;
    limit[i] = lim;
    sent[i]  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_tag.delete();
    for (int i = 0; i < int'(N); i++) setup_src(i, 1'b0, 0, 0);
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0]    hold_data;
    logic [TAGW-1:0] hold_tag;
    int unsigned     n;

    // Reset with every requester valid.
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) setup_src(i, 1'b1, i * 16, 8);
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);

    // Fairness: bursts of four per source in order, then back to source 0.
    for (int k = 0; k < 32; k++) exp_tag.push_back((k / 4) % 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
    run_until_sent(200);
    drain();

    // Backpressure mid-burst.
    do_reset();
    for (int i = 0; i < int'(N); i++) setup_src(i, 1'b1, 64 + i * 16, 4);
    for (int k = 0; k < 16; k++) exp_tag.push_back((k / 4) % 4);
    drive_inputs();
    repeat (7) step();
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    hold_data = out_data;
    hold_tag  = out_tag;
    repeat (3) begin
      step();
      check("bp_data_stable", 32'(out_data), 32'(hold_data));
      check("bp_tag_stable", 32'(out_tag), 32'(hold_tag));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    run_until_sent(200);
    drain();

    // Single stream: four words every five clocks.
    do_reset();
    setup_src(2, 1'b1, 10, 16);
    for (int k = 0; k < 16; k++) exp_tag.push_back(2);
    drive_inputs();
    acc_cnt = 0;
    repeat (20) step();
    check("single_rate", acc_cnt, 32'd16);
    drain();

    // Early release: requester 1 stops after two words, requester 3 is next.
    do_reset();
    setup_src(1, 1'b1, 32, 2);
    setup_src(3, 1'b1, 48, 4);
    exp_tag.push_back(1);
    exp_tag.push_back(1);
    for (int k = 0; k < 4; k++) exp_tag.push_back(3);
    drive_inputs();
    run_until_sent(50);
    drain();

    // Asynchronous reset while an output word is pending.
    do_reset();
    for (int i = 0; i < int'(N); i++) setup_src(i, 1'b1, 128 + i * 16, 8);
    drive_inputs();
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    step();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    sb.delete();
    exp_tag.delete();
    for (int i = 0; i < int'(N); i++) sent[i] = 0;
    for (int k = 0; k < 4; k++) exp_tag.push_back(0);
    exp_tag.push_back(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
    run_until_sent(200);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
